// File: rtl/alu_pkg.sv
// Shared funct codes and the multiply/divide sequencer state encoding.
// Used by both the execute-stage ALU and its bench.
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_if.sv
// EX-stage request/result bundle: issue side drives operands under valid/ready,
// the ALU answers with a registered one-cycle result pulse.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             out_valid;
  logic [WIDTH-1:0] dataOut;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, funct, dataA, dataB,
    input  in_ready, out_valid, dataOut, zero, busy
  );

  modport slave (
    input  in_valid, funct, dataA, dataB,
    output in_ready, out_valid, dataOut, zero, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// Unsigned shift-add multiply / restoring divide, one bit per cycle, WIDTH cycles
// per op; owns HI/LO. done_o marks the final iteration edge, with res_lo_o the new LO.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output state_e           state_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, b_q, hi_q, lo_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  // rem/quo double as the {upper, lower} halves of the product during MUL.
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    rem_d     = mul_sum[WIDTH:1];
    quo_d     = {mul_sum[0], quo_q[WIDTH-1:1]};
    if (state_q == DIV) begin
      rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], div_ge};
    end
  end

  assign done_o   = (state_q != IDLE) && (cnt_q == CNT_W'(WIDTH - 1));
  assign res_lo_o = quo_d;
  assign state_o  = state_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= op_div_i ? DIV : MUL;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= a_i;
            b_q     <= b_i;
          end
        end
        default: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (done_o) begin
            state_q <= IDLE;
            hi_q    <= rem_d;
            lo_q    <= quo_d;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle ops give a registered result one cycle after accept;
// MULTU/DIVU hold in_ready low for WIDTH cycles and pulse out_valid with LO on completion.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_muldiv_if.slave bus
);
  state_e           state;
  logic             accept, is_md, done;
  logic [WIDTH-1:0] res_lo, hi, lo, result_d;
  logic             out_valid_q, zero_q;
  logic [WIDTH-1:0] data_out_q;

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.dataOut   = data_out_q;
  assign bus.zero      = zero_q;

  assign is_md  = (bus.funct == F_MULTU) || (bus.funct == F_DIVU);
  assign accept = bus.in_valid && bus.in_ready;

  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept && is_md),
    .op_div_i (bus.funct == F_DIVU),
    .a_i      (bus.dataA),
    .b_i      (bus.dataB),
    .state_o  (state),
    .done_o   (done),
    .res_lo_o (res_lo),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  always_comb begin
    result_d = '0;
    case (bus.funct)
      F_AND:  result_d = bus.dataA & bus.dataB;
      F_OR:   result_d = bus.dataA | bus.dataB;
      F_XOR:  result_d = bus.dataA ^ bus.dataB;
      F_NOR:  result_d = ~(bus.dataA | bus.dataB);
      F_ADD:  result_d = bus.dataA + bus.dataB;
      F_SUB:  result_d = bus.dataA - bus.dataB;
      F_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
      F_SLTU: result_d = {{(WIDTH-1){1'b0}}, (bus.dataA < bus.dataB)};
      F_MFHI: result_d = hi;
      F_MFLO: result_d = lo;
      default: result_d = '0;
    endcase
  end

  // done can only fire while in_ready is low, so it never collides with a single-cycle accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      zero_q      <= 1'b0;
    end else if (accept && !is_md) begin
      out_valid_q <= 1'b1;
      data_out_q  <= result_d;
      zero_q      <= (result_d == '0);
    end else if (done) begin
      out_valid_q <= 1'b1;
      data_out_q  <= res_lo;
      zero_q      <= (res_lo == '0);
    end else begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: a 32-bit and an 8-bit instance on one clock,
// driven and sampled on the falling edge against hand-computed results.
module tb_alu_muldiv;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset32, reset8;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_muldiv_if #(.WIDTH(32)) bus32 ();
  alu_muldiv_if #(.WIDTH(8))  bus8 ();

  alu_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset32), .bus(bus32));
  alu_muldiv #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8),  .bus(bus8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus32.in_valid = 1'b1;
    bus32.funct    = f;
    bus32.dataA    = a;
    bus32.dataB    = b;
  endtask

  task automatic drive8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
    bus8.in_valid = 1'b1;
    bus8.funct    = f;
    bus8.dataA    = a;
    bus8.dataB    = b;
  endtask

  task automatic expect32(input string tag, input logic [31:0] v, input logic z);
    check({tag, "_vld"},  bus32.out_valid, 1);
    check({tag, "_dat"},  bus32.dataOut, v);
    check({tag, "_zero"}, bus32.zero, z);
  endtask

  task automatic expect8(input string tag, input logic [7:0] v, input logic z);
    check({tag, "_vld"},  bus8.out_valid, 1);
    check({tag, "_dat"},  bus8.dataOut, v);
    check({tag, "_zero"}, bus8.zero, z);
  endtask

  // Issue a MULTU/DIVU at the current falling edge, wait for the result, then read HI.
  task automatic md32(input string tag, input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, input bit hold,
                      input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n   = 0;
    int low = 0;
    drive32(f, a, b);
    do begin
      @(negedge clk);
      n++;
      if (!hold) bus32.in_valid = 1'b0;
      if (!bus32.in_ready) low++;
    end while (!bus32.out_valid && n < 100);
    check({tag, "_latency"}, n, 33);
    check({tag, "_ready_low_cycles"}, low, 32);
    check({tag, "_lo"}, bus32.dataOut, exp_lo);
    check({tag, "_ready_back"}, bus32.in_ready, 1);
    check({tag, "_busy_clear"}, bus32.busy, 0);
    drive32(F_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    expect32({tag, "_mfhi"}, exp_hi, exp_hi == 32'h0);
    bus32.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    bus32.in_valid = 1'b0; bus32.funct = 6'd0; bus32.dataA = '0; bus32.dataB = '0;
    bus8.in_valid  = 1'b0; bus8.funct  = 6'd0; bus8.dataA  = '0; bus8.dataB  = '0;
    reset32 = 1'b1;
    reset8  = 1'b1;
    repeat (3) @(negedge clk);
    reset32 = 1'b0;
    reset8  = 1'b0;
    @(negedge clk);

    check("rst_ready",  bus32.in_ready, 1);
    check("rst_valid",  bus32.out_valid, 0);
    check("rst_data",   bus32.dataOut, 0);
    check("rst_zero",   bus32.zero, 0);
    check("rst_busy",   bus32.busy, 0);
    check("rst_ready8", bus8.in_ready, 1);

    drive32(F_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    expect32("rst_hi", 32'h0, 1'b1);
    drive32(F_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    expect32("rst_lo", 32'h0, 1'b1);

    drive32(F_ADD, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    expect32("add_wrap", 32'h0, 1'b1);
    drive32(F_SUB, 32'd5, 32'd5);
    @(negedge clk);
    expect32("sub_eq", 32'h0, 1'b1);
    drive32(F_SLT, 32'h8000_0000, 32'h1);
    @(negedge clk);
    expect32("slt_neg", 32'h1, 1'b0);
    drive32(F_NOR, 32'hF0F0_0000, 32'h0000_0F0F);
    @(negedge clk);
    expect32("nor", 32'h0F0F_F0F0, 1'b0);
    bus32.in_valid = 1'b0;
    @(negedge clk);
    check("valid_drop", bus32.out_valid, 0);

    md32("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    md32("divu_100_7", F_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    md32("divu_by0", F_DIVU, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd9);

    drive32(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) begin
      @(negedge clk);
      bus32.in_valid = 1'b0;
    end
    check("mid_busy", bus32.busy, 1);
    reset32 = 1'b1;
    #1;
    check("mid_rst_busy",  bus32.busy, 0);
    check("mid_rst_ready", bus32.in_ready, 1);
    check("mid_rst_valid", bus32.out_valid, 0);
    check("mid_rst_data",  bus32.dataOut, 0);
    @(negedge clk);
    reset32 = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.out_valid) pulses++;
    end
    check("mid_rst_no_late_pulse", pulses, 0);
    drive32(F_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    expect32("mid_rst_hi", 32'h0, 1'b1);
    drive32(F_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    expect32("mid_rst_lo", 32'h0, 1'b1);
    bus32.in_valid = 1'b0;

    drive8(F_MULTU, 8'd200, 8'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus8.in_valid = 1'b0;
    end while (!bus8.out_valid && n < 100);
    check("w8_mul_latency", n, 9);
    check("w8_mul_lo", bus8.dataOut, 8'h58);
    drive8(F_MFHI, 8'h0, 8'h0);
    @(negedge clk);
    expect8("w8_mfhi", 8'h02, 1'b0);
    drive8(F_SLTU, 8'h80, 8'h01);
    @(negedge clk);
    expect8("w8_sltu", 8'h00, 1'b1);
    drive8(F_SLT, 8'h80, 8'h01);
    @(negedge clk);
    expect8("w8_slt", 8'h01, 1'b0);
    drive8(6'h3F, 8'hFF, 8'hFF);
    @(negedge clk);
    expect8("w8_unknown", 8'h00, 1'b1);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    check("w8_valid_drop", bus8.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
